// File: rtl/ball_motion_sched.sv
// Per-frame motion scheduler: steps every ball through one shared step/bounce unit
// on each v_sync falling edge, then publishes all positions together.
module ball_motion_sched #(
    parameter int NUM_BALLS     = 4,
    parameter int SCREEN_WIDTH  = 800,
    parameter int SCREEN_HEIGHT = 600,
    parameter int BALL_DIM      = 25,
    parameter int BALL_SPEED    = 5,
    localparam int IDXW = (NUM_BALLS > 1) ? $clog2(NUM_BALLS) : 1
) (
    input  logic            clk_100mhz,
    input  logic            reset,
    input  logic            v_sync,
    input  logic [IDXW-1:0] rd_idx,
    output logic [9:0]      rd_x,
    output logic [9:0]      rd_y,
    input  logic            cfg_valid,
    output logic            cfg_ready,
    input  logic [IDXW-1:0] cfg_idx,
    input  logic [9:0]      cfg_x,
    input  logic [9:0]      cfg_y,
    input  logic            cfg_vx,
    input  logic            cfg_vy,
    output logic            busy,
    output logic            frame_done,
    output logic            overrun,
    output logic [15:0]     frame_count
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_UPDATE = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    localparam logic [10:0]     SPEED    = 11'(BALL_SPEED);
    localparam logic [9:0]      MAX_X    = 10'(SCREEN_WIDTH - BALL_DIM);
    localparam logic [9:0]      MAX_Y    = 10'(SCREEN_HEIGHT - BALL_DIM);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_BALLS - 1);

    logic [1:0]      state;
    logic [IDXW-1:0] idx;
    logic            axis_y;
    logic            v_sync_q;
    logic            tick;
    logic            cfg_hit;

    logic [9:0] work_x  [NUM_BALLS];
    logic [9:0] work_y  [NUM_BALLS];
    logic       work_vx [NUM_BALLS];
    logic       work_vy [NUM_BALLS];
    logic [9:0] pub_x   [NUM_BALLS];
    logic [9:0] pub_y   [NUM_BALLS];

    logic [9:0]  cur_pos;
    logic [9:0]  cur_max;
    logic        cur_dir;
    logic [10:0] step_res;

    // Returns {new_dir, new_pos}; the sum is formed at 11 bits so it never wraps.
    function automatic logic [10:0] step_axis(input logic [9:0] pos, input logic dir,
                                              input logic [9:0] max_pos);
        logic [10:0] up;
        up = {1'b0, pos} + SPEED;
        if (dir) begin
            if (up >= {1'b0, max_pos}) return {1'b0, max_pos};
            return {1'b1, up[9:0]};
        end
        if ({1'b0, pos} <= SPEED) return {1'b1, 10'd0};
        return {1'b0, pos - SPEED[9:0]};
    endfunction

    function automatic logic [9:0] clamp_pos(input logic [9:0] v, input logic [9:0] max_pos);
        return (v > max_pos) ? max_pos : v;
    endfunction

    function automatic logic [9:0] rst_x(input int i);
        return 10'(150 + 100 * i);
    endfunction

    function automatic logic [9:0] rst_y(input int i);
        return 10'(100 + 60 * i);
    endfunction

    always_comb begin
        tick      = v_sync_q & ~v_sync;
        busy      = (state != ST_IDLE);
        cfg_ready = (state == ST_IDLE);
        cfg_hit   = cfg_valid && (int'(cfg_idx) < NUM_BALLS);
        cur_pos   = axis_y ? work_y[idx] : work_x[idx];
        cur_dir   = axis_y ? work_vy[idx] : work_vx[idx];
        cur_max   = axis_y ? MAX_Y : MAX_X;
        step_res  = step_axis(cur_pos, cur_dir, cur_max);
    end

    // Read port sees published positions only, never mid-sweep working values.
    always_comb begin
        rd_x = 10'd0;
        rd_y = 10'd0;
        if (int'(rd_idx) < NUM_BALLS) begin
            rd_x = pub_x[rd_idx];
            rd_y = pub_y[rd_idx];
        end
    end

    always_ff @(posedge clk_100mhz) begin
        if (reset) begin
            for (int i = 0; i < NUM_BALLS; i++) begin
                work_x[i]  <= rst_x(i);
                work_y[i]  <= rst_y(i);
                work_vx[i] <= (i % 2 == 0);
                work_vy[i] <= 1'b1;
                pub_x[i]   <= rst_x(i);
                pub_y[i]   <= rst_y(i);
            end
            state       <= ST_IDLE;
            idx         <= '0;
            axis_y      <= 1'b0;
            v_sync_q    <= 1'b1;
            frame_done  <= 1'b0;
            overrun     <= 1'b0;
            frame_count <= 16'd0;
        end else begin
            v_sync_q   <= v_sync;
            frame_done <= 1'b0;
            if (tick && state != ST_IDLE) overrun <= 1'b1;

            case (state)
                ST_IDLE: begin
                    // A config write and a tick in the same cycle: the write lands
                    // first and the sweep then steps from the configured values.
                    if (cfg_hit) begin
                        work_x[cfg_idx]  <= clamp_pos(cfg_x, MAX_X);
                        work_y[cfg_idx]  <= clamp_pos(cfg_y, MAX_Y);
                        work_vx[cfg_idx] <= cfg_vx;
                        work_vy[cfg_idx] <= cfg_vy;
                        pub_x[cfg_idx]   <= clamp_pos(cfg_x, MAX_X);
                        pub_y[cfg_idx]   <= clamp_pos(cfg_y, MAX_Y);
                    end
                    if (tick) begin
                        state  <= ST_UPDATE;
                        idx    <= '0;
                        axis_y <= 1'b0;
                    end
                end
                ST_UPDATE: begin
                    if (axis_y) begin
                        work_y[idx]  <= step_res[9:0];
                        work_vy[idx] <= step_res[10];
                    end else begin
                        work_x[idx]  <= step_res[9:0];
                        work_vx[idx] <= step_res[10];
                    end
                    axis_y <= ~axis_y;
                    if (axis_y) begin
                        if (idx == LAST_IDX) state <= ST_COMMIT;
                        else idx <= idx + IDXW'(1);
                    end
                end
                ST_COMMIT: begin
                    pub_x       <= work_x;
                    pub_y       <= work_y;
                    frame_count <= frame_count + 16'd1;
                    frame_done  <= 1'b1;
                    state       <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ball_motion_sched.sv
// Bench for ball_motion_sched: directed scenarios plus random traffic, checked every
// cycle against a frame-level behavioural model.
module tb_ball_motion_sched;

    localparam int N     = 4;
    localparam int SPEED = 5;
    localparam int MAXX  = 775;
    localparam int MAXY  = 575;

    logic        clk_100mhz = 1'b0;
    logic        reset      = 1'b1;
    logic        v_sync     = 1'b1;
    logic [1:0]  rd_idx     = 2'd0;
    logic [9:0]  rd_x;
    logic [9:0]  rd_y;
    logic        cfg_valid  = 1'b0;
    logic        cfg_ready;
    logic [1:0]  cfg_idx    = 2'd0;
    logic [9:0]  cfg_x      = 10'd0;
    logic [9:0]  cfg_y      = 10'd0;
    logic        cfg_vx     = 1'b0;
    logic        cfg_vy     = 1'b0;
    logic        busy;
    logic        frame_done;
    logic        overrun;
    logic [15:0] frame_count;

    ball_motion_sched dut (
        .clk_100mhz (clk_100mhz),
        .reset      (reset),
        .v_sync     (v_sync),
        .rd_idx     (rd_idx),
        .rd_x       (rd_x),
        .rd_y       (rd_y),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_idx    (cfg_idx),
        .cfg_x      (cfg_x),
        .cfg_y      (cfg_y),
        .cfg_vx     (cfg_vx),
        .cfg_vy     (cfg_vy),
        .busy       (busy),
        .frame_done (frame_done),
        .overrun    (overrun),
        .frame_count(frame_count)
    );

    always #5 clk_100mhz = ~clk_100mhz;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Frame-level model: a sweep's result is computed the moment it is accepted and
    // becomes visible once the busy window has elapsed.
    int m_wx[N], m_wy[N], m_vx[N], m_vy[N], m_px[N], m_py[N];
    int m_busy, m_fc, m_ovr, m_fd, m_vq;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_wx[i] = 150 + 100 * i;
            m_wy[i] = 100 + 60 * i;
            m_vx[i] = (i % 2 == 0) ? 1 : 0;
            m_vy[i] = 1;
            m_px[i] = m_wx[i];
            m_py[i] = m_wy[i];
        end
        m_busy = 0; m_fc = 0; m_ovr = 0; m_fd = 0; m_vq = 1;
    endtask

    task automatic move(input int pos, input int dir, input int mx, output int np, output int nd);
        if (dir != 0) begin
            if (pos + SPEED >= mx) begin np = mx; nd = 0; end
            else begin np = pos + SPEED; nd = 1; end
        end else begin
            if (pos <= SPEED) begin np = 0; nd = 1; end
            else begin np = pos - SPEED; nd = 0; end
        end
    endtask

    task automatic model_edge();
        int tk, np, nd, ci;
        if (reset) begin
            model_reset();
            return;
        end
        tk   = (m_vq == 1 && v_sync == 1'b0) ? 1 : 0;
        m_fd = 0;
        if (m_busy > 0) begin
            if (tk != 0) m_ovr = 1;
            m_busy--;
            if (m_busy == 0) begin
                m_px = m_wx;
                m_py = m_wy;
                m_fc = (m_fc + 1) % 65536;
                m_fd = 1;
            end
        end else begin
            if (cfg_valid) begin
                ci = int'(cfg_idx);
                m_wx[ci] = (int'(cfg_x) > MAXX) ? MAXX : int'(cfg_x);
                m_wy[ci] = (int'(cfg_y) > MAXY) ? MAXY : int'(cfg_y);
                m_vx[ci] = cfg_vx ? 1 : 0;
                m_vy[ci] = cfg_vy ? 1 : 0;
                m_px[ci] = m_wx[ci];
                m_py[ci] = m_wy[ci];
            end
            if (tk != 0) begin
                for (int i = 0; i < N; i++) begin
                    move(m_wx[i], m_vx[i], MAXX, np, nd); m_wx[i] = np; m_vx[i] = nd;
                    move(m_wy[i], m_vy[i], MAXY, np, nd); m_wy[i] = np; m_vy[i] = nd;
                end
                m_busy = 2 * N + 1;
            end
        end
        m_vq = v_sync ? 1 : 0;
    endtask

    task automatic cycle_body();
        #1;
        check("busy", 32'(busy), 32'(m_busy > 0));
        check("cfg_ready", 32'(cfg_ready), 32'(m_busy == 0));
        check("frame_done", 32'(frame_done), m_fd);
        check("overrun", 32'(overrun), m_ovr);
        check("frame_count", 32'(frame_count), m_fc);
        check("rd_x", 32'(rd_x), m_px[rd_idx]);
        check("rd_y", 32'(rd_y), m_py[rd_idx]);
        model_edge();
        @(negedge clk_100mhz);
    endtask

    task automatic step_cycle();
        rd_idx = 2'($urandom_range(0, N - 1));
        cycle_body();
    endtask

    task automatic run(input int n);
        v_sync = 1'b1; cfg_valid = 1'b0; reset = 1'b0;
        repeat (n) step_cycle();
    endtask

    task automatic frame();
        v_sync = 1'b0;
        step_cycle();
        run(2 * N + 3);
    endtask

    task automatic peek(input string tag, input logic [1:0] i, input int ex, input int ey);
        rd_idx = i;
        #1;
        check({tag, "_x"}, 32'(rd_x), ex);
        check({tag, "_y"}, 32'(rd_y), ey);
    endtask

    task automatic cfg_write(input logic [1:0] i, input int x, input int y, input logic vx,
                             input logic vy);
        int accepted;
        accepted = 0;
        cfg_idx = i; cfg_x = 10'(x); cfg_y = 10'(y); cfg_vx = vx; cfg_vy = vy;
        cfg_valid = 1'b1;
        for (int k = 0; k < 40 && accepted == 0; k++) begin
            accepted = (m_busy == 0) ? 1 : 0;
            step_cycle();
        end
        if (accepted == 0) check("cfg_accept_timeout", 0, 1);
        cfg_valid = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk_100mhz);
        model_reset();
        reset = 1'b1;
        step_cycle();
        reset = 1'b0;
        peek("rst_b0", 2'd0, 150, 100);
        peek("rst_b3", 2'd3, 450, 280);

        // First frame: exact busy / frame_done / publish timing.
        v_sync = 1'b0;
        step_cycle();
        v_sync = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            rd_idx = 2'd0;
            #1;
            check("tl_busy", 32'(busy), 32'(k <= 9));
            check("tl_fd", 32'(frame_done), 32'(k == 10));
            check("tl_x0", 32'(rd_x), (k < 10) ? 150 : 155);
            cycle_body();
        end
        peek("f1_b0", 2'd0, 155, 105);
        peek("f1_b1", 2'd1, 245, 165);
        check("f1_count", 32'(frame_count), 1);

        // Upper bounce on x.
        cfg_write(2'd1, 770, 200, 1'b1, 1'b1);
        frame();
        peek("ub1", 2'd1, 775, 205);
        frame();
        peek("ub2", 2'd1, 770, 210);

        // Lower bounce on y.
        cfg_write(2'd2, 300, 3, 1'b1, 1'b0);
        frame();
        peek("lb1", 2'd2, 305, 0);
        frame();
        peek("lb2", 2'd2, 310, 5);
        cfg_write(2'd2, 300, 5, 1'b1, 1'b0);
        frame();
        peek("lb3", 2'd2, 305, 0);

        // Overrun: second falling edge three cycles into the sweep.
        reset = 1'b1;
        step_cycle();
        run(2);
        check("ovr_before", 32'(overrun), 0);
        v_sync = 1'b0; step_cycle();
        v_sync = 1'b1; step_cycle(); step_cycle();
        v_sync = 1'b0; step_cycle();
        run(12);
        check("ovr_set", 32'(overrun), 1);
        check("ovr_count", 32'(frame_count), 1);
        peek("ovr_b0", 2'd0, 155, 105);

        // Config and tick in the same cycle.
        cfg_idx = 2'd0; cfg_x = 10'd400; cfg_y = 10'd300; cfg_vx = 1'b1; cfg_vy = 1'b1;
        cfg_valid = 1'b1; v_sync = 1'b0;
        step_cycle();
        run(12);
        peek("sim_b0", 2'd0, 405, 305);

        // Config held while busy lands on the first idle cycle.
        v_sync = 1'b0; step_cycle();
        v_sync = 1'b1;
        cfg_write(2'd3, 600, 400, 1'b0, 1'b0);
        peek("busycfg", 2'd3, 600, 400);
        frame();
        peek("busycfg_f", 2'd3, 595, 395);

        // Reset mid-sweep aborts without publishing.
        v_sync = 1'b0; step_cycle();
        v_sync = 1'b1; repeat (3) step_cycle();
        reset = 1'b1; step_cycle();
        run(12);
        check("rms_count", 32'(frame_count), 0);
        peek("rms_b0", 2'd0, 150, 100);
        peek("rms_b3", 2'd3, 450, 280);
        frame();
        peek("rms_f_b0", 2'd0, 155, 105);
        check("rms_f_count", 32'(frame_count), 1);

        // Random traffic.
        for (int k = 0; k < 800; k++) begin
            reset     = ($urandom_range(0, 299) == 0);
            v_sync    = ($urandom_range(0, 9) != 0);
            cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_idx   = 2'($urandom_range(0, N - 1));
            cfg_x     = 10'($urandom_range(0, 1023));
            cfg_y     = 10'($urandom_range(0, 1023));
            cfg_vx    = 1'($urandom_range(0, 1));
            cfg_vy    = 1'($urandom_range(0, 1));
            step_cycle();
        end
        run(12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
